// File: rtl/ofdm_fft_symbol_sequencer.sv
// ofdm_fft_symbol_sequencer
//   Runs the 32-bin OFDM FFT datapath one symbol at a time.
//   - Takes one input byte over a valid/ready handshake.
//   - Holds the byte on o_fft_byte, issues a single-cycle o_fft_start and
//     waits for i_fft_done.
//   - Steps the external bin mux (o_bin_sel) and streams the BINS complex
//     results out over a registered valid/ready port.
//
// Ports
//   i_clk, i_rst_n            clock; asynchronous active-low reset
//   i_byte_valid/i_byte       byte input stream; o_byte_ready is high in IDLE only
//   o_fft_byte, o_fft_start   byte and start pulse to the FFT datapath
//   i_fft_done                FFT cycle-done flag (only sampled in RUN)
//   o_bin_sel                 select for the external result mux
//   i_bin_re/i_bin_im         selected bin data from that mux
//   o_re/o_im/o_valid/o_last  result stream; i_ready is the downstream ready
//   o_busy                    FSM not in IDLE
//   o_err                     sticky watchdog timeout flag
//   o_sym_cnt                 completed-symbol counter (wraps)
//
// Optional feature: define FFTSEQ_TIMEOUT_EN to add a RUN-state watchdog.
//   When it fires, the symbol is dropped and o_err is set. When the macro is
//   not defined, RUN waits forever and o_err is tied to 0.
module ofdm_fft_symbol_sequencer #(
  parameter int WORD_SIZE      = 16,
  parameter int DATA_LENGTH    = 8,
  parameter int BINS           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_byte_valid,
  input  logic [DATA_LENGTH-1:0]   i_byte,
  output logic                     o_byte_ready,
  output logic [DATA_LENGTH-1:0]   o_fft_byte,
  output logic                     o_fft_start,
  input  logic                     i_fft_done,
  output logic [$clog2(BINS)-1:0]  o_bin_sel,
  input  logic [WORD_SIZE-1:0]     i_bin_re,
  input  logic [WORD_SIZE-1:0]     i_bin_im,
  output logic [WORD_SIZE-1:0]     o_re,
  output logic [WORD_SIZE-1:0]     o_im,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_last,
  output logic                     o_busy,
  output logic                     o_err,
  output logic [15:0]              o_sym_cnt
);
  localparam int BW = $clog2(BINS);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_UNLOAD} state_t;
  state_t state_q, state_d;

  logic pending_q;    // at least one bin of this symbol has not been loaded yet
  logic load;         // output register takes the current mux bin
  logic xfer_last;    // final beat of the symbol accepted downstream
  logic timeout_hit;
  logic last_bin;

  assign last_bin  = (o_bin_sel == BW'(BINS-1));
  assign load      = (state_q == S_UNLOAD) && pending_q && (!o_valid || i_ready);
  assign xfer_last = o_valid && i_ready && o_last;

`ifdef FFTSEQ_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES+1) > 8) ? $clog2(TIMEOUT_CYCLES+1) : 8;
  logic [TW-1:0] wd_q;
  logic          err_q;

  // The counter is held at zero outside RUN, so it always starts fresh on entry.
  // It fires on the TIMEOUT_CYCLES-th RUN cycle with no done seen.
  assign timeout_hit = (state_q == S_RUN) && !i_fft_done && (wd_q == TW'(TIMEOUT_CYCLES-1));
  assign o_err       = err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q != S_RUN) wd_q <= '0;
      else if (!i_fft_done) wd_q <= wd_q + TW'(1);
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign o_err              = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    o_byte_ready = 1'b0;
    o_fft_start  = 1'b0;
    o_busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b0;
        if (i_byte_valid) state_d = S_START;
      end
      S_START: begin
        o_fft_start = 1'b1;
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (i_fft_done)       state_d = S_UNLOAD;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_UNLOAD: begin
        if (xfer_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fft_byte <= '0;
      o_bin_sel  <= '0;
      pending_q  <= 1'b0;
      o_re       <= '0;
      o_im       <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_sym_cnt  <= '0;
    end else begin
      if ((state_q == S_IDLE) && i_byte_valid) o_fft_byte <= i_byte;

      if ((state_q == S_RUN) && i_fft_done) begin
        o_bin_sel <= '0;
        pending_q <= 1'b1;
      end

      if (load) begin
        o_re      <= i_bin_re;
        o_im      <= i_bin_im;
        o_valid   <= 1'b1;
        o_last    <= last_bin;
        o_bin_sel <= o_bin_sel + BW'(1);   // wraps to 0 after the final bin
        if (last_bin) pending_q <= 1'b0;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end

      if (xfer_last) o_sym_cnt <= o_sym_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ofdm_fft_symbol_sequencer.sv
// Directed bench for ofdm_fft_symbol_sequencer.
// The result-mux model returns re = 2*bin and im = -bin.
module tb_ofdm_fft_symbol_sequencer;
  localparam int WS   = 16;
  localparam int DL   = 8;
  localparam int BINS = 32;
  localparam int BW   = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_byte_valid;
  logic [DL-1:0] i_byte;
  logic          o_byte_ready;
  logic [DL-1:0] o_fft_byte;
  logic          o_fft_start;
  logic          i_fft_done;
  logic [BW-1:0] o_bin_sel;
  logic [WS-1:0] i_bin_re, i_bin_im;
  logic [WS-1:0] o_re, o_im;
  logic          o_valid, i_ready, o_last, o_busy, o_err;
  logic [15:0]   o_sym_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;

  always #5 clk = ~clk;

  ofdm_fft_symbol_sequencer #(
    .WORD_SIZE(WS), .DATA_LENGTH(DL), .BINS(BINS), .TIMEOUT_CYCLES(20)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_byte_valid(i_byte_valid), .i_byte(i_byte), .o_byte_ready(o_byte_ready),
    .o_fft_byte(o_fft_byte), .o_fft_start(o_fft_start), .i_fft_done(i_fft_done),
    .o_bin_sel(o_bin_sel), .i_bin_re(i_bin_re), .i_bin_im(i_bin_im),
    .o_re(o_re), .o_im(o_im), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_busy(o_busy), .o_err(o_err), .o_sym_cnt(o_sym_cnt)
  );

  // result mux model
  assign i_bin_re = {{(WS-BW-1){1'b0}}, o_bin_sel, 1'b0};
  assign i_bin_im = WS'(0) - {{(WS-BW){1'b0}}, o_bin_sel};

  always @(posedge clk) if (o_fft_start) n_start <= n_start + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Presents a byte and returns on the negedge where o_fft_start is high.
  task automatic start_symbol(input logic [7:0] b, input bit keep_valid);
    int t;
    i_byte       = b;
    i_byte_valid = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!o_fft_start && t < 200);
    chk("start_seen", o_fft_start, 1);
    chk("fft_byte", o_fft_byte, b);
    if (!keep_valid) i_byte_valid = 1'b0;
  endtask

  // Pulses done after dly cycles, then returns on the negedge of UNLOAD entry.
  task automatic pulse_done(input int dly);
    for (int k = 0; k < dly; k++) begin
      tick();
      if (k == 0) chk("start_one_cycle", o_fft_start, 0);
    end
    i_fft_done = 1'b1;
    tick();
    i_fft_done = 1'b0;
    chk("unload_entry_valid", o_valid, 0);
    chk("unload_entry_sel", o_bin_sel, 0);
    chk("unload_entry_busy", o_busy, 1);
  endtask

  // Collects BINS beats.
  // With rnd set, i_ready toggles randomly and the held data is checked.
  task automatic collect(input bit rnd, input string tag);
    int beat, cyc, first, lastc;
    bit hold, r;
    logic [32:0] held;
    beat = 0; cyc = 0; first = -1; lastc = -1; hold = 0; held = '0;
    while (beat < BINS && cyc < 3000) begin
      tick(); cyc++;
      if (hold) chk({tag, "_hold"}, {o_valid, o_last, o_re, o_im}, {1'b1, held});
      r = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
      i_ready = r;
      if (o_valid && r) begin
        if (first < 0) first = cyc;
        lastc = cyc;
        chk({tag, "_beat"}, {o_last, o_re, o_im},
            {(beat == BINS-1), 16'(2*beat), 16'(0 - beat)});
        beat++;
        hold = 0;
      end else if (o_valid) begin
        hold = 1;
        held = {o_last, o_re, o_im};
      end else begin
        hold = 0;
      end
    end
    chk({tag, "_nbeats"}, beat, BINS);
    if (!rnd) begin
      chk({tag, "_first_lat"}, first, 1);
      chk({tag, "_no_bubble"}, lastc - first, BINS-1);
    end
    tick();
    i_ready = 1'b1;
    chk({tag, "_end_valid"}, o_valid, 0);
    chk({tag, "_end_ready"}, o_byte_ready, 1);
  endtask

  initial begin
    int s0;
    bit any_valid;
    rst_n = 1'b0; i_byte_valid = 1'b0; i_byte = '0; i_fft_done = 1'b0; i_ready = 1'b1;
    #2;
    chk("rst_ready", o_byte_ready, 1);
    chk("rst_outs", {o_valid, o_last, o_busy, o_err, o_fft_start}, 0);
    chk("rst_cnt_sel", {o_sym_cnt, o_bin_sel, o_fft_byte}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // basic symbol
    s0 = n_start;
    start_symbol(8'hA5, 0);
    pulse_done(5);
    collect(0, "basic");
    chk("basic_starts", n_start - s0, 1);
    chk("basic_symcnt", o_sym_cnt, 1);
    chk("basic_byte_hold", o_fft_byte, 8'hA5);

    // random backpressure
    start_symbol(8'h3C, 0);
    pulse_done(2);
    collect(1, "bp");
    chk("bp_symcnt", o_sym_cnt, 2);

    // done during START is ignored
    start_symbol(8'h5A, 0);
    i_fft_done = 1'b1;
    tick();
    i_fft_done = 1'b0;
    repeat (6) tick();
    chk("early_busy", o_busy, 1);
    chk("early_valid", o_valid, 0);
    pulse_done(0);
    collect(0, "early");
    chk("early_symcnt", o_sym_cnt, 3);

    // back-to-back, fresh counter
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    s0 = n_start;
    start_symbol(8'h11, 1); i_byte = 8'h22;
    pulse_done(3); collect(0, "b2b0");
    chk("b2b0_byte_hold", o_fft_byte, 8'h11);
    start_symbol(8'h22, 1); i_byte = 8'h33;
    pulse_done(1); collect(0, "b2b1");
    start_symbol(8'h33, 0);
    pulse_done(4); collect(0, "b2b2");
    chk("b2b_starts", n_start - s0, 3);
    chk("b2b_symcnt", o_sym_cnt, 3);

    // reset mid-UNLOAD
    start_symbol(8'h77, 0);
    pulse_done(1);
    i_ready = 1'b0;
    tick(); tick();
    chk("mid_valid_pre", o_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_sel", o_bin_sel, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_ready", o_byte_ready, 1);
    chk("mid_rst_cnt", o_sym_cnt, 0);
    tick();
    rst_n = 1'b1; i_ready = 1'b1;
    any_valid = 0;
    repeat (6) begin tick(); if (o_valid || o_busy) any_valid = 1; end
    chk("mid_no_resume", any_valid, 0);

    // watchdog
    start_symbol(8'h99, 0);
`ifdef FFTSEQ_TIMEOUT_EN
    repeat (20) tick();
    chk("to_pre_busy", {o_busy, o_err}, 2'b10);
    tick();
    chk("to_busy", o_busy, 0);
    chk("to_err", o_err, 1);
    chk("to_valid", o_valid, 0);
    chk("to_symcnt", o_sym_cnt, 0);
`else
    repeat (1000) tick();
    chk("wait_busy", o_busy, 1);
    chk("wait_valid", o_valid, 0);
    chk("wait_err", o_err, 0);
    pulse_done(0);
    collect(0, "post_wait");
    chk("post_wait_symcnt", o_sym_cnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
